// File: rtl/ramb_asym_dp.sv
// Single-clock true dual-port RAM with asymmetric port widths, per-port write modes,
// sync output set and collision flag. Define RAMB_ASYM_DO_REG_EN for a 2-cycle read path.

module ramb_asym_port_out #(
  parameter int W = 2,
  parameter MODE = "WRITE_FIRST",
  parameter logic [W-1:0] SRVAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         we,
  input  logic         set,
  input  logic [W-1:0] wdata,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] dout
);
  localparam bit IS_WF = (MODE == "WRITE_FIRST");
  localparam bit IS_RF = (MODE == "READ_FIRST");

  logic [W-1:0] do1;

  // rdata is the array content before this edge's writes, so a port reading
  // an address the other port is writing always returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do1 <= '0;
    end else if (en) begin
      if (set)        do1 <= SRVAL;
      else if (!we)   do1 <= rdata;
      else if (IS_WF) do1 <= wdata;
      else if (IS_RF) do1 <= rdata;
    end
  end

`ifdef RAMB_ASYM_DO_REG_EN
  logic [1:0]   vld_pipe;
  logic [W-1:0] do2;

  assign vld_pipe[0] = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      do2         <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[1]) do2 <= do1;
    end
  end

  assign dout = do2;
`else
  assign dout = do1;
`endif
endmodule

module ramb_asym_dp #(
  parameter int TOTAL_BITS = 4096,
  parameter int WIDTH_A = 2,
  parameter int WIDTH_B = 8,
  parameter int ADDR_A = $clog2(TOTAL_BITS / WIDTH_A),
  parameter int ADDR_B = $clog2(TOTAL_BITS / WIDTH_B),
  parameter WRITE_MODE_A = "WRITE_FIRST",
  parameter WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [WIDTH_A-1:0] SRVAL_A = '0,
  parameter logic [WIDTH_B-1:0] SRVAL_B = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_A-1:0] addra,
  input  logic [WIDTH_A-1:0] dia,
  input  logic              ena,
  input  logic              wea,
  input  logic              rsta,
  output logic [WIDTH_A-1:0] doa,
  input  logic [ADDR_B-1:0] addrb,
  input  logic [WIDTH_B-1:0] dib,
  input  logic              enb,
  input  logic              web,
  input  logic              rstb,
  output logic [WIDTH_B-1:0] dob,
  output logic              coll
);
  localparam int RATIO   = WIDTH_B / WIDTH_A;
  localparam int LOG_R   = $clog2(RATIO);
  localparam int DEPTH_A = TOTAL_BITS / WIDTH_A;

  generate
    if (WIDTH_A < 1 || (WIDTH_A & (WIDTH_A - 1)) != 0 ||
        WIDTH_B < 1 || (WIDTH_B & (WIDTH_B - 1)) != 0 ||
        TOTAL_BITS < WIDTH_B || (TOTAL_BITS & (TOTAL_BITS - 1)) != 0 ||
        WIDTH_A > WIDTH_B || RATIO > 64) begin : g_bad_width
      $error("ramb_asym_dp: illegal width/depth parameters");
    end
    if (WRITE_MODE_A != "WRITE_FIRST" && WRITE_MODE_A != "READ_FIRST" &&
        WRITE_MODE_A != "NO_CHANGE") begin : g_bad_mode_a
      $error("ramb_asym_dp: illegal WRITE_MODE_A");
    end
    if (WRITE_MODE_B != "WRITE_FIRST" && WRITE_MODE_B != "READ_FIRST" &&
        WRITE_MODE_B != "NO_CHANGE") begin : g_bad_mode_b
      $error("ramb_asym_dp: illegal WRITE_MODE_B");
    end
  endgenerate

  // storage is kept at port A granularity; a B word is RATIO consecutive A lanes
  logic [WIDTH_A-1:0] mem [DEPTH_A];

  logic [RATIO-1:0][ADDR_A-1:0]  lane_idx;
  logic [RATIO-1:0][WIDTH_A-1:0] rdb_lane;
  logic [RATIO-1:0][WIDTH_A-1:0] dib_lane;
  logic [WIDTH_A-1:0]            rda;
  logic [WIDTH_B-1:0]            rdb;

  assign dib_lane = dib;

  generate
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      assign lane_idx[k] = (ADDR_A'(addrb) << LOG_R) | ADDR_A'(k);
      assign rdb_lane[k] = mem[lane_idx[k]];
    end
  endgenerate

  assign rda = mem[addra];
  assign rdb = rdb_lane;

  // no reset on the array; writes are blocked while rst_n is low.
  // B is applied after A so B wins on a write/write overlap.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (ena && wea) mem[addra] <= dia;
      if (enb && web) begin
        for (int k = 0; k < RATIO; k++) mem[lane_idx[k]] <= dib_lane[k];
      end
    end
  end

  logic ovl, coll_d, coll_q;

  assign ovl    = (ADDR_B'(addra >> LOG_R) == addrb);
  assign coll_d = ena && enb && ovl && (wea || web);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

`ifdef RAMB_ASYM_DO_REG_EN
  logic coll_q2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q2 <= 1'b0;
    else        coll_q2 <= coll_q;
  end
  assign coll = coll_q2;
`else
  assign coll = coll_q;
`endif

  ramb_asym_port_out #(.W(WIDTH_A), .MODE(WRITE_MODE_A), .SRVAL(SRVAL_A)) u_out_a (
    .clk(clk), .rst_n(rst_n), .en(ena), .we(wea), .set(rsta),
    .wdata(dia), .rdata(rda), .dout(doa)
  );

  ramb_asym_port_out #(.W(WIDTH_B), .MODE(WRITE_MODE_B), .SRVAL(SRVAL_B)) u_out_b (
    .clk(clk), .rst_n(rst_n), .en(enb), .we(web), .set(rstb),
    .wdata(dib), .rdata(rdb), .dout(dob)
  );
endmodule

// File: tb/tb_ramb_asym_dp.sv
// Scoreboard bench for ramb_asym_dp: three instances share stimulus and differ in port A write mode.

module tb_ramb_asym_dp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] addra;
  logic [1:0]  dia;
  logic        ena, wea, rsta;
  logic [8:0]  addrb;
  logic [7:0]  dib;
  logic        enb, web, rstb;

  logic [1:0] doa, doa_rf, doa_nc;
  logic [7:0] dob, dob_rf, dob_nc;
  logic       coll, coll_rf, coll_nc;

  always #5 clk = ~clk;

  ramb_asym_dp #(.WRITE_MODE_A("WRITE_FIRST"), .SRVAL_B(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .addra(addra), .dia(dia), .ena(ena), .wea(wea), .rsta(rsta),
    .doa(doa), .addrb(addrb), .dib(dib), .enb(enb), .web(web), .rstb(rstb), .dob(dob), .coll(coll)
  );
  ramb_asym_dp #(.WRITE_MODE_A("READ_FIRST"), .SRVAL_B(8'hA5)) dut_rf (
    .clk(clk), .rst_n(rst_n), .addra(addra), .dia(dia), .ena(ena), .wea(wea), .rsta(rsta),
    .doa(doa_rf), .addrb(addrb), .dib(dib), .enb(enb), .web(web), .rstb(rstb), .dob(dob_rf), .coll(coll_rf)
  );
  ramb_asym_dp #(.WRITE_MODE_A("NO_CHANGE"), .SRVAL_B(8'hA5)) dut_nc (
    .clk(clk), .rst_n(rst_n), .addra(addra), .dia(dia), .ena(ena), .wea(wea), .rsta(rsta),
    .doa(doa_nc), .addrb(addrb), .dib(dib), .enb(enb), .web(web), .rstb(rstb), .dob(dob_nc), .coll(coll_nc)
  );

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sel(input int sig);
    case (sig)
      0:       return {6'b0, doa};
      1:       return dob;
      2:       return {7'b0, coll};
      3:       return {6'b0, doa_rf};
      default: return {6'b0, doa_nc};
    endcase
  endfunction

  // monitor: outputs are sampled at the falling edge, away from the active edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        nchk++;
        nerr++;
        $display("FAIL %s: missed sample at cycle %0d", e.name, e.cyc);
      end else begin
        check(e.name, sel(e.sig), e.val);
      end
    end
  end

  task automatic drv(input logic ea, wa, ra, input logic [10:0] aa, input logic [1:0] da,
                     input logic eb, wb, rb, input logic [8:0] ab, input logic [7:0] db);
    @(negedge clk);
    ena = ea; wea = wa; rsta = ra; addra = aa; dia = da;
    enb = eb; web = wb; rstb = rb; addrb = ab; dib = db;
  endtask

  task automatic expv(input int sig, input logic [7:0] v, input string nm);
    sb.push_back('{cyc + 1, sig, v, nm});
  endtask

  initial begin
    rst_n = 1'b1;
    ena = 0; wea = 0; rsta = 0; addra = '0; dia = '0;
    enb = 0; web = 0; rstb = 0; addrb = '0; dib = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_doa", {6'b0, doa}, 8'h00);
    check("reset_dob", dob, 8'h00);
    check("reset_coll", {7'b0, coll}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // write a=5, then read it and pull reset between edges
    drv(1,1,0,11'd5,2'b10, 0,0,0,9'd0,8'h00); expv(0, 8'h02, "wf_a5");
    drv(1,0,0,11'd5,2'b00, 0,0,0,9'd0,8'h00);
    @(posedge clk); #1;
    check("rd_a5_pre", {6'b0, doa}, 8'h02);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_doa", {6'b0, doa}, 8'h00);
    check("midrst_dob", dob, 8'h00);
    check("midrst_coll", {7'b0, coll}, 8'h00);
    ena = 1; wea = 1; dia = 2'b11; addra = 11'd5;
    @(posedge clk);
    @(negedge clk);
    ena = 0; wea = 0;
    @(negedge clk) rst_n = 1'b1;
    drv(1,0,0,11'd5,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h02, "rd_a5_post"); expv(2, 8'h00, "coll_idle");

    // cross-width: B word 3 = A words 12..15
    drv(0,0,0,11'd0,2'b00, 1,1,0,9'd3,8'hE4); expv(1, 8'hE4, "wf_b3");
    drv(1,0,0,11'd12,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h00, "x_a12");
    drv(1,0,0,11'd13,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h01, "x_a13");
    drv(1,0,0,11'd14,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h02, "x_a14");
    drv(1,0,0,11'd15,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h03, "x_a15");

    // write modes on port A
    drv(1,1,0,11'd7,2'b01, 0,0,0,9'd0,8'h00); expv(0, 8'h01, "pre_a7_wf"); expv(4, 8'h03, "pre_a7_nc");
    drv(1,1,0,11'd7,2'b10, 0,0,0,9'd0,8'h00);
    expv(0, 8'h02, "wm_wf"); expv(3, 8'h01, "wm_rf"); expv(4, 8'h03, "wm_nc");

    // collisions
    drv(0,0,0,11'd0,2'b00, 1,1,0,9'd1,8'hFF); expv(1, 8'hFF, "pre_b1");
    drv(1,1,0,11'd8,2'b11, 1,1,0,9'd2,8'h00); expv(2, 8'h01, "coll_ww");
    drv(1,1,0,11'd4,2'b00, 1,0,0,9'd1,8'h00); expv(1, 8'hFF, "coll_wr_old"); expv(2, 8'h01, "coll_consec");
    drv(0,0,0,11'd0,2'b00, 1,0,0,9'd2,8'h00); expv(1, 8'h00, "ww_bwins"); expv(2, 8'h00, "coll_clear");
    drv(0,0,0,11'd0,2'b00, 1,0,0,9'd1,8'h00); expv(1, 8'hFC, "wr_new");
    drv(1,0,0,11'd13,2'b00, 1,1,0,9'd3,8'h1B);
    expv(0, 8'h01, "coll_rw_old"); expv(2, 8'h01, "coll_rw"); expv(1, 8'h1B, "wf_b3b");
    drv(1,0,0,11'd13,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h02, "rw_new");

    // sync set and hold
    drv(1,0,1,11'd13,2'b00, 0,0,0,9'd0,8'h00); expv(0, 8'h00, "seta"); expv(3, 8'h00, "seta_rf");
    drv(0,0,0,11'd0,2'b00, 1,1,1,9'd5,8'h3C); expv(1, 8'hA5, "setb");
    drv(0,0,0,11'd0,2'b00, 0,0,0,9'd9,8'h00); expv(1, 8'hA5, "holdb");
    drv(0,0,0,11'd0,2'b00, 0,0,0,9'd10,8'h00); expv(1, 8'hA5, "holdb2");
    drv(1,0,0,11'd21,2'b00, 1,0,0,9'd5,8'h00);
    expv(1, 8'h3C, "setb_wrote"); expv(0, 8'h03, "rr_a21"); expv(2, 8'h00, "rr_nocoll");
    drv(0,0,0,11'd0,2'b00, 0,0,0,9'd0,8'h00);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      nchk += sb.size();
      nerr += sb.size();
      $display("FAIL drain_timeout: %0d pending expected responses, required 0", sb.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
